// File: rtl/morphle_pkg.sv
// Shared definitions for the yblock configuration sequencer.
// Default geometry, timing constants and the sequencer state type.
package morphle_pkg;

  localparam int DEF_BLOCKWIDTH  = 16;
  localparam int DEF_BLOCKHEIGHT = 16;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_CCLK_HALF   = 2;
  localparam int DEF_RST_CYCLES  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_SETUP,
    S_HIGH,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/ycfg_sequencer_if.sv
// Config word handshake: word_valid/word_data offered, word_ready back.
// master = word source (host side), slave = sequencer.
interface ycfg_sequencer_if #(
  parameter int W = 16
);

  logic         word_valid;
  logic [W-1:0] word_data;
  logic         word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );

endinterface

// File: rtl/ycfg_fifo.sv
// Synchronous word FIFO with flush; DEPTH must be a power of two.
// Ports: clk/rst, flush, push/din, pop/dout, count, full, empty.
module ycfg_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ycfg_sequencer.sv
// Loads config rows into a yblock chain with a generated two-phase confclk.
// Ports: wb_clk_i/wb_rst_i, start/abort, word (slave), yblock cfg, readback, status.
module ycfg_sequencer
  import morphle_pkg::*;
#(
  parameter int BLOCKWIDTH  = DEF_BLOCKWIDTH,
  parameter int BLOCKHEIGHT = DEF_BLOCKHEIGHT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CCLK_HALF   = DEF_CCLK_HALF,
  parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   abort,
  ycfg_sequencer_if.slave        word,
  output logic                   cfg_reset,
  output logic                   confclk,
  output logic [BLOCKWIDTH-1:0]  cfgin,
  input  logic [BLOCKWIDTH-1:0]  cfgout,
  output logic                   rb_valid,
  output logic [BLOCKWIDTH-1:0]  rb_data,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(BLOCKHEIGHT+1)-1:0] rows_done
);

  localparam int RW   = $clog2(BLOCKHEIGHT + 1);
  localparam int PMAX = (CCLK_HALF > RST_CYCLES) ? CCLK_HALF : RST_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  seq_state_t state;
  seq_state_t state_n;

  logic [PW-1:0]         ph;
  logic                  ph_last;
  logic                  push;
  logic                  pop;
  logic                  cap;
  logic                  inc;
  logic                  clr;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [BLOCKWIDTH-1:0] head;

  // ready reflects the pre-pop fill; a word offered with abort is dropped
  assign word.word_ready = !full;
  assign push = word.word_valid && !full && !abort;

  ycfg_fifo #(
    .W     (BLOCKWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (abort),
    .push  (push),
    .din   (word.word_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign ph_last = (state == S_RESET) ?
                   (ph == PW'(RST_CYCLES - 1)) :
                   (ph == PW'(CCLK_HALF - 1));

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign rb_valid = (state == S_HIGH) && (ph == '0);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cap     = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RESET;
          clr     = 1'b1;
        end
      end
      S_RESET: begin
        if (ph_last) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ph_last) begin
          cap     = 1'b1;
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (ph_last) begin
          inc = 1'b1;
          if (rows_done == RW'(BLOCKHEIGHT - 1)) begin
            state_n = S_DONE;
          end else if (count != '0) begin
            pop     = 1'b1;
            state_n = S_SETUP;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // abort wins over everything, including the row count of the current row
    if (abort) begin
      state_n = S_IDLE;
      pop     = 1'b0;
      cap     = 1'b0;
      inc     = 1'b0;
      clr     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      ph        <= '0;
      rows_done <= '0;
      cfgin     <= '0;
      rb_data   <= '0;
      confclk   <= 1'b0;
      cfg_reset <= 1'b0;
    end else begin
      state <= state_n;
      ph    <= (state_n != state) ? '0 : ph + PW'(1);
      if (clr) begin
        rows_done <= '0;
      end else if (inc) begin
        rows_done <= rows_done + RW'(1);
      end
      if (pop) cfgin <= head;
      if (cap) rb_data <= cfgout;
      // decoded from next state so both pins come straight from flops
      confclk   <= (state_n == S_HIGH);
      cfg_reset <= (state_n == S_RESET);
    end
  end

endmodule

// File: tb/tb_ycfg_sequencer.sv
// Directed bench for ycfg_sequencer with a shift-chain yblock model.
// Checks load timing, readback, underflow, backpressure, abort and async reset.
module tb_ycfg_sequencer;

  localparam int BW = 16;
  localparam int BH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_reset;
  logic          confclk;
  logic [BW-1:0] cfgin;
  logic [BW-1:0] cfgout;
  logic          rb_valid;
  logic [BW-1:0] rb_data;
  logic          busy;
  logic          done;
  logic [4:0]    rows_done;

  ycfg_sequencer_if #(.W(BW)) wif ();

  ycfg_sequencer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start     (start),
    .abort     (abort),
    .word      (wif.slave),
    .cfg_reset (cfg_reset),
    .confclk   (confclk),
    .cfgin     (cfgin),
    .cfgout    (cfgout),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data),
    .busy      (busy),
    .done      (done),
    .rows_done (rows_done)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] chain [BH];

  initial begin
    for (int i = 0; i < BH; i++) chain[i] = '0;
  end

  always @(posedge confclk) begin
    for (int i = BH - 1; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= cfgin;
  end

  assign cfgout = chain[BH-1];

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int fi = 0;
  int gap = 0;
  int next_ok = 0;
  logic [BW-1:0] feed [$];
  int rise_cyc [$];
  logic [BW-1:0] rise_in [$];
  logic [BW-1:0] rbq [$];
  int done_cyc;
  int done_cnt;
  int high_cnt;
  int busy_cnt;
  int rst_cnt;
  int rst_first;
  logic pcc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (fi < feed.size() && cyc >= next_ok) begin
      wif.word_valid = 1'b1;
      wif.word_data  = feed[fi];
    end else begin
      wif.word_valid = 1'b0;
      wif.word_data  = '0;
    end
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    rise_in.delete();
    rbq.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    high_cnt  = 0;
    busy_cnt  = 0;
    rst_cnt   = 0;
    rst_first = -1;
    pcc       = confclk;
  endtask

  task automatic tick();
    logic acc;
    int c0;
    c0  = cyc;
    acc = wif.word_valid && wif.word_ready && !abort && (fi < feed.size());
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      fi++;
      next_ok = c0 + gap;
    end
    if (confclk) high_cnt++;
    if (busy) busy_cnt++;
    if (confclk && !pcc) begin
      rise_cyc.push_back(cyc);
      rise_in.push_back(cfgin);
    end
    pcc = confclk;
    if (cfg_reset) begin
      if (rst_cnt == 0) rst_first = cyc;
      rst_cnt++;
    end
    if (rb_valid) rbq.push_back(rb_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    drive();
  endtask

  task automatic begin_load(input int first_ok);
    start   = 1'b1;
    cyc     = 0;
    next_ok = first_ok;
    clear_log();
    drive();
    tick();
    start = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_feed(input logic [BW-1:0] base, input int n);
    feed.delete();
    fi = 0;
    for (int k = 0; k < n; k++) feed.push_back(base + BW'(k));
  endtask

  task automatic chk_cleared(input string p);
    chk({p, "_ready"}, wif.word_ready, 1);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_confclk"}, confclk, 0);
    chk({p, "_cfg_reset"}, cfg_reset, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_rb_valid"}, rb_valid, 0);
    chk({p, "_rows"}, rows_done, 0);
    chk({p, "_cfgin"}, cfgin, 0);
    chk({p, "_rb_data"}, rb_data, 0);
  endtask

  task automatic chk_full_load(input string p, input logic [BW-1:0] first,
                               input logic [BW-1:0] last);
    chk({p, "_rises"}, rise_cyc.size(), 16);
    for (int k = 0; k < rise_cyc.size(); k++) begin
      chk($sformatf("%s_rise%0d", p, k), rise_cyc[k], 6 + 4 * k);
    end
    if (rise_in.size() == 16) begin
      chk({p, "_cfgin_first"}, rise_in[0], first);
      chk({p, "_cfgin_last"}, rise_in[15], last);
    end
    chk({p, "_rst_first"}, rst_first, 1);
    chk({p, "_rst_cnt"}, rst_cnt, 2);
    chk({p, "_done_cyc"}, done_cyc, 68);
    chk({p, "_done_cnt"}, done_cnt, 1);
    chk({p, "_busy_cnt"}, busy_cnt, 68);
    chk({p, "_high_cnt"}, high_cnt, 32);
    chk({p, "_rows"}, rows_done, 16);
  endtask

  initial begin
    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cleared("reset");

    // load 1: pattern A = 0x0001..0x0010
    set_feed(16'h0001, 16);
    drive();
    repeat (4) tick();
    chk("preload_full_ready", wif.word_ready, 0);
    begin_load(0);
    run_to(70);
    chk_full_load("load1", 16'h0001, 16'h0010);

    // load 2: pattern B, readback must return pattern A in order
    set_feed(16'hB000, 16);
    drive();
    repeat (4) tick();
    begin_load(0);
    run_to(70);
    chk_full_load("load2", 16'hB000, 16'hB00F);
    chk("rb_count", rbq.size(), 16);
    for (int k = 0; k < rbq.size(); k++) begin
      chk($sformatf("rb%0d", k), rbq[k], k + 1);
    end

    // load 3: underflow, one word every 10 cycles
    set_feed(16'hC000, 16);
    gap = 10;
    begin_load(0);
    run_to(170);
    gap = 0;
    chk("uf_rises", rise_cyc.size(), 16);
    if (rise_cyc.size() == 16) begin
      chk("uf_rise0", rise_cyc[0], 6);
      chk("uf_rise1", rise_cyc[1], 14);
      chk("uf_rise15", rise_cyc[15], 154);
    end
    chk("uf_high_cnt", high_cnt, 32);
    chk("uf_done_cyc", done_cyc, 156);
    chk("uf_done_cnt", done_cnt, 1);
    chk("uf_busy_cnt", busy_cnt, 156);
    chk("uf_rows", rows_done, 16);

    // backpressure: 6 words offered while idle
    set_feed(16'hD001, 6);
    next_ok = 0;
    drive();
    repeat (4) tick();
    chk("bp_ready_after4", wif.word_ready, 0);
    repeat (2) tick();
    chk("bp_accepted", fi, 4);
    begin_load(0);
    run_to(3);
    chk("bp_ready_c3", wif.word_ready, 0);
    run_to(4);
    chk("bp_ready_c4", wif.word_ready, 1);
    chk("bp_fi_c4", fi, 4);
    run_to(26);
    chk("bp_fi_c26", fi, 6);
    chk("ab_pre_confclk", confclk, 1);
    chk("ab_pre_rows", rows_done, 5);
    chk("ab_pre_cfgin", cfgin, 16'hD006);

    // abort in first HIGH cycle of row 5, with start and a word offered
    abort = 1'b1;
    start = 1'b1;
    wif.word_valid = 1'b1;
    wif.word_data  = 16'hDEAD;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_confclk", confclk, 0);
    chk("ab_busy", busy, 0);
    chk("ab_cfg_reset", cfg_reset, 0);
    chk("ab_done", done, 0);
    chk("ab_rows", rows_done, 5);
    chk("ab_ready", wif.word_ready, 1);
    run_to(33);
    chk("ab_no_done", done_cnt, 0);
    chk("ab_idle_busy", busy, 0);
    chk("ab_rows_hold", rows_done, 5);

    // FIFO must be empty: new load sits in WAIT until a word arrives
    set_feed(16'h5A5A, 1);
    begin_load(10);
    run_to(10);
    chk("empty_no_rise", rise_cyc.size(), 0);
    chk("empty_busy", busy, 1);
    run_to(12);
    chk("setup_cfgin", cfgin, 16'h5A5A);
    chk("setup_confclk", confclk, 0);

    // async reset in the middle of SETUP
    #2;
    rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    feed.delete();
    fi = 0;
    tick();
    rst = 1'b0;

    // full load after reset
    set_feed(16'hE000, 16);
    next_ok = 0;
    drive();
    repeat (4) tick();
    begin_load(0);
    run_to(70);
    chk_full_load("post_rst", 16'hE000, 16'hE00F);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
